// File: rtl/echo_pkg.sv
// Shared types and constants for the echo responder: default sizes,
// output-stage state encoding and the pointer-width helper.
package echo_pkg;

  localparam int ECHO_WIDTH_DEFAULT = 32;
  localparam int ECHO_DEPTH_DEFAULT = 4;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/echo_responder_if.sv
// enq request / heard indication handshake bundle. master = initiator and
// consumer side, slave = the responder.
interface echo_responder_if #(
  parameter int WIDTH = echo_pkg::ECHO_WIDTH_DEFAULT
);
  logic             enq__ENA;
  logic [WIDTH-1:0] enq_v;
  logic             enq__RDY;
  logic             heard__ENA;
  logic [WIDTH-1:0] heard_v;
  logic             heard__RDY;

  modport master (
    output enq__ENA, enq_v, heard__RDY,
    input  enq__RDY, heard__ENA, heard_v
  );

  modport slave (
    input  enq__ENA, enq_v, heard__RDY,
    output enq__RDY, heard__ENA, heard_v
  );
endinterface

// File: rtl/echo_fifo.sv
// DEPTH-entry FIFO used by echo_responder; full/empty/head decode purely
// from registered count and read pointer.
module echo_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = ECHO_DEPTH_DEFAULT,
  parameter int WIDTH = ECHO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // push and pop together leave the occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/echo_responder.sv
// Echo responder: buffers enq payloads in echo_fifo and replays them on heard
// through a one-entry output register. ECHO_RESPONDER_COUNT_EN adds echo_count.
module echo_responder
  import echo_pkg::*;
#(
  parameter int DEPTH = ECHO_DEPTH_DEFAULT,
  parameter int WIDTH = ECHO_WIDTH_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  echo_responder_if.slave   io
`ifdef ECHO_RESPONDER_COUNT_EN
  ,
  output logic [31:0]       echo_count
`endif
);
  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] heard_v_q, heard_v_d;
  logic             rdy_en_q, rdy_en_d;
  logic             fifo_full, fifo_empty, fifo_pop, push, xfer;
  logic [WIDTH-1:0] fifo_head;

  // rdy_en_q keeps enq__RDY low through reset and rises on the first edge after
  assign io.enq__RDY   = rdy_en_q && !fifo_full;
  assign io.heard__ENA = (state_q == OUT_FULL);
  assign io.heard_v    = heard_v_q;
  assign push          = io.enq__ENA && io.enq__RDY;

  echo_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk       (CLK),
    .rst       (nRST),
    .push      (push),
    .push_data (io.enq_v),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    heard_v_d = heard_v_q;
    fifo_pop  = 1'b0;
    rdy_en_d  = 1'b1;
    xfer      = (state_q == OUT_FULL) && io.heard__RDY;
    case (state_q)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          heard_v_d = fifo_head;
          state_d   = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (xfer) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            heard_v_d = fifo_head;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q   <= OUT_EMPTY;
      heard_v_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      heard_v_q <= heard_v_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

`ifdef ECHO_RESPONDER_COUNT_EN
  logic [31:0] echo_count_q, echo_count_d;

  assign echo_count = echo_count_q;

  always_comb begin
    echo_count_d = echo_count_q;
    if (xfer) echo_count_d = echo_count_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) echo_count_q <= '0;
    else      echo_count_q <= echo_count_d;
  end
`endif
endmodule

// File: tb/tb_echo_responder.sv
// Directed bench for echo_responder: scoreboard queue filled on accepted enq,
// drained on accepted heard; covers reset, latency, backpressure, streaming.
module tb_echo_responder;
  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;
  int   n_xfer = 0;
  logic [31:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_v = '0;

  echo_responder_if #(.WIDTH(32)) io ();

`ifdef ECHO_RESPONDER_COUNT_EN
  logic [31:0] echo_count;
`endif

  echo_responder #(.DEPTH(4), .WIDTH(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .io   (io)
`ifdef ECHO_RESPONDER_COUNT_EN
    ,
    .echo_count (echo_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: ordering, hold-while-stalled, scoreboard push on accepted enq
  always @(negedge CLK) begin
    if (nRST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_ena", io.heard__ENA, 1);
        chk("hold_v", io.heard_v, prev_v);
      end
      if (io.heard__ENA && io.heard__RDY) begin
        n_xfer++;
        if (sb.size() == 0) chk("unexpected_heard", io.heard__ENA, 0);
        else chk("order", io.heard_v, sb.pop_front());
      end
      if (io.enq__ENA && io.enq__RDY) sb.push_back(io.enq_v);
      else if (io.enq__ENA) $display("note: enq while enq__RDY=0, payload %h dropped", io.enq_v);
      prev_stall = io.heard__ENA && !io.heard__RDY;
      prev_v     = io.heard_v;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b1;
    io.enq__ENA = 1'b1;
    io.enq_v = 32'h0000_0011;
    io.heard__RDY = 1'b1;

    // reset held with enq asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_enq_rdy", io.enq__RDY, 0);
      chk("rst_heard_ena", io.heard__ENA, 0);
      chk("rst_heard_v", io.heard_v, 0);
    end
`ifdef ECHO_RESPONDER_COUNT_EN
    chk("rst_count", echo_count, 0);
`endif
    tick();
    nRST = 1'b0;
    io.enq__ENA = 1'b0;
    @(negedge CLK);
    chk("rel_enq_rdy_low", io.enq__RDY, 0);
    tick();
    @(negedge CLK);
    chk("rel_enq_rdy", io.enq__RDY, 1);
    repeat (3) tick();
    @(negedge CLK);
    chk("rel_nothing_queued", io.heard__ENA, 0);

    // single echo, latency 2
    tick();
    io.enq__ENA = 1'b1;
    io.enq_v = 32'hDEAD_BEEF;
    tick();
    io.enq__ENA = 1'b0;
    @(negedge CLK);
    chk("lat_n1_ena", io.heard__ENA, 0);
    tick();
    @(negedge CLK);
    chk("lat_n2_ena", io.heard__ENA, 1);
    chk("lat_n2_v", io.heard_v, 32'hDEAD_BEEF);
    tick();
    @(negedge CLK);
    chk("lat_n3_ena", io.heard__ENA, 0);
`ifdef ECHO_RESPONDER_COUNT_EN
    chk("single_count", echo_count, 1);
`endif

    // fill under backpressure: 4 in FIFO + 1 in output register
    io.heard__RDY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      io.enq__ENA = 1'b1;
      io.enq_v = i;
      @(negedge CLK);
      chk("fill_rdy", io.enq__RDY, 1);
    end
    tick();
    io.enq_v = 32'd6;
    @(negedge CLK);
    chk("full_rdy", io.enq__RDY, 0);
    tick();
    io.enq__ENA = 1'b0;
    @(negedge CLK);
    chk("full_rdy_hold", io.enq__RDY, 0);
    chk("full_head", io.heard_v, 1);
    tick();
    io.heard__RDY = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk("burst_ena", io.heard__ENA, 1);
      chk("burst_v", io.heard_v, k);
      tick();
    end
    @(negedge CLK);
    chk("burst_done", io.heard__ENA, 0);
    chk("burst_sb", sb.size(), 0);

    // streaming one per cycle
    for (int i = 0; i < 100; i++) begin
      tick();
      io.enq__ENA = 1'b1;
      io.enq_v = 32'd100 + i;
      @(negedge CLK);
      chk("stream_rdy", io.enq__RDY, 1);
      if (i >= 2) chk("stream_ena", io.heard__ENA, 1);
    end
    tick();
    io.enq__ENA = 1'b0;
    drain();

    // random consumer backpressure
    for (int i = 0; i < 200; i++) begin
      tick();
      io.heard__RDY = 1'($urandom_range(0, 1));
      io.enq__ENA = 1'($urandom_range(0, 1)) && io.enq__RDY;
      io.enq_v = $urandom;
    end
    tick();
    io.enq__ENA = 1'b0;
    io.heard__RDY = 1'b1;
    drain();

    // reset mid-stream with 3 entries buffered
    io.heard__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      io.enq__ENA = 1'b1;
      io.enq_v = 32'hA000_0000 + i;
    end
    tick();
    io.enq__ENA = 1'b0;
    tick();
    #2;
    chk("pre_rst_ena", io.heard__ENA, 1);
    nRST = 1'b1;
    sb.delete();
    #1;
    chk("midrst_ena", io.heard__ENA, 0);
    chk("midrst_rdy", io.enq__RDY, 0);
`ifdef ECHO_RESPONDER_COUNT_EN
    chk("midrst_count", echo_count, 0);
`endif
    tick();
    nRST = 1'b0;
    io.heard__RDY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge CLK);
      chk("post_rst_no_stale", io.heard__ENA, 0);
    end
    tick();
    io.enq__ENA = 1'b1;
    io.enq_v = 32'h0000_0055;
    tick();
    io.enq__ENA = 1'b0;
    drain();

`ifdef ECHO_RESPONDER_COUNT_EN
    // counter wrap
    io.heard__RDY = 1'b0;
    tick();
    io.enq__ENA = 1'b1;
    io.enq_v = 32'h0000_0077;
    tick();
    io.enq__ENA = 1'b0;
    repeat (3) tick();
    force dut.echo_count_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.echo_count_q;
    tick();
    @(negedge CLK);
    chk("wrap_pre", echo_count, 32'hFFFF_FFFF);
    tick();
    io.heard__RDY = 1'b1;
    tick();
    @(negedge CLK);
    chk("wrap_post", echo_count, 0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
